// File: rtl/alu_sequencer.sv
// Multi-cycle ALU operation sequencer holding the NZCV flag register.
// Optional CMP opcode (op 8) enabled by defining ALU_SEQ_CMP_EN.
module alu_sequencer #(
    parameter logic CARRY_RESET    = 1'b0,
    parameter bit   LOGIC_KEEPS_CV = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [3:0]  flags,
    output logic [31:0] alu_ina,
    output logic [31:0] alu_inb,
    output logic [3:0]  alu_aluc,
    output logic        alu_cin,
    input  logic [31:0] alu_out,
    input  logic        alu_cout,
    input  logic        alu_negative,
    input  logic        alu_zero,
    input  logic        alu_overflow
);
    typedef enum logic [1:0] {S_IDLE, S_P1, S_P2, S_FIN} state_t;

    localparam logic [3:0] OP_PASS = 4'd0, OP_ADD = 4'd1, OP_ADC = 4'd2, OP_SUB = 4'd3,
                           OP_NEG  = 4'd4, OP_AND = 4'd5, OP_OR  = 4'd6, OP_CLR = 4'd7;

    state_t      r_state;
    logic [3:0]  r_op;
    logic [31:0] r_a, r_b, r_t, r_result;
    logic [3:0]  r_flags;
    logic        r_busy, r_done;

    logic        w_is_cmp, w_two_pass, w_logic_op, w_nop, w_fin;
    logic [3:0]  w_alu_flags;

`ifdef ALU_SEQ_CMP_EN
    assign w_is_cmp = (r_op == 4'd8);
`else
    assign w_is_cmp = 1'b0;
`endif

    assign w_two_pass  = (r_op == OP_SUB) || (r_op == OP_NEG) || w_is_cmp;
    assign w_logic_op  = (r_op == OP_PASS) || (r_op == OP_AND) || (r_op == OP_OR) || (r_op == OP_CLR);
    assign w_nop       = r_op[3] && !w_is_cmp;
    assign w_fin       = ((r_state == S_P1) && !w_two_pass) || (r_state == S_P2);
    assign w_alu_flags = {alu_negative, alu_zero, alu_cout, alu_overflow};

    // ALU drive decodes straight from registered state, so it holds steady across each pass.
    always_comb begin
        alu_ina  = 32'd0;
        alu_inb  = 32'd0;
        alu_aluc = 4'b1000;
        alu_cin  = 1'b0;
        if (r_state == S_P1) begin
            alu_ina = r_a;
            alu_inb = r_b;
            case (r_op)
                OP_PASS: alu_aluc = 4'b0000;
                OP_ADD:  alu_aluc = 4'b0100;
                OP_ADC:  begin alu_aluc = 4'b0101; alu_cin = r_flags[1]; end
                OP_SUB:  alu_aluc = 4'b0011;
                OP_NEG:  alu_aluc = 4'b0010;
                OP_AND:  alu_aluc = 4'b0111;
                OP_OR:   alu_aluc = 4'b0110;
                OP_CLR:  alu_aluc = 4'b1000;
                default: begin
                    if (w_is_cmp) begin
                        alu_aluc = 4'b0011;
                    end else begin
                        alu_ina = 32'd0;
                        alu_inb = 32'd0;
                    end
                end
            endcase
        end else if (r_state == S_P2) begin
            alu_aluc = 4'b0101;
            alu_cin  = 1'b1;
            if (r_op == OP_NEG) begin
                alu_ina = r_t;
                alu_inb = 32'd0;
            end else begin
                alu_ina = r_a;
                alu_inb = r_t;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_op     <= 4'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_t      <= 32'd0;
            r_result <= 32'd0;
            r_flags  <= {2'b00, CARRY_RESET, 1'b0};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_FIN: begin
                    if (start) begin
                        r_op    <= op;
                        r_a     <= opa;
                        r_b     <= opb;
                        r_busy  <= 1'b1;
                        r_state <= S_P1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_P1: begin
                    if (w_two_pass) begin
                        r_t     <= alu_out;
                        r_state <= S_P2;
                    end
                end
                default: ;
            endcase
            if (w_fin) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_FIN;
                if (!w_nop && !w_is_cmp)
                    r_result <= alu_out;
                if (!w_nop)
                    r_flags <= (LOGIC_KEEPS_CV && w_logic_op) ? {alu_negative, alu_zero, r_flags[1:0]}
                                                              : w_alu_flags;
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign flags  = r_flags;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 32-bit ALU attached to its buses.
module tb_alu_sequencer;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] opa = 32'd0, opb = 32'd0;
    logic        busy, done;
    logic [31:0] result, alu_ina, alu_inb, alu_out;
    logic [3:0]  flags, alu_aluc;
    logic        alu_cin, alu_cout, alu_negative, alu_zero, alu_overflow;
    int          n_vec = 0, n_err = 0;

    alu_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .result(result), .flags(flags),
        .alu_ina(alu_ina), .alu_inb(alu_inb), .alu_aluc(alu_aluc), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_cout(alu_cout), .alu_negative(alu_negative),
        .alu_zero(alu_zero), .alu_overflow(alu_overflow)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: 0000 pass A, 0010 NOT A, 0011 NOT B, 0100 add, 0101 add+cin, 0110 or, 0111 and, 1000 zero.
    logic [32:0] sum;
    always_comb begin
        sum          = 33'd0;
        alu_out      = 32'd0;
        alu_cout     = 1'b0;
        alu_overflow = 1'b0;
        case (alu_aluc)
            4'b0000: alu_out = alu_ina;
            4'b0010: alu_out = ~alu_ina;
            4'b0011: alu_out = ~alu_inb;
            4'b0100, 4'b0101: begin
                sum = {1'b0, alu_ina} + {1'b0, alu_inb} + {32'd0, (alu_aluc[0] & alu_cin)};
                alu_out      = sum[31:0];
                alu_cout     = sum[32];
                alu_overflow = (alu_ina[31] == alu_inb[31]) && (sum[31] != alu_ina[31]);
            end
            4'b0110: alu_out = alu_ina | alu_inb;
            4'b0111: alu_out = alu_ina & alu_inb;
            default: alu_out = 32'd0;
        endcase
        alu_negative = alu_out[31];
        alu_zero     = (alu_out == 32'd0);
    end

    // Sample start at the next rising edge (edge k); return 1ns after it with start low.
    task automatic start_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; opa = a; opb = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_vec++; if (result !== 32'd0) begin n_err++; $display("FAIL reset_result got %h want 0", result); end
        n_vec++; if (flags !== 4'b0000) begin n_err++; $display("FAIL reset_flags got %b want 0000", flags); end
        n_vec++; if ({alu_aluc, alu_ina, alu_inb, alu_cin} !== {4'b1000, 65'd0}) begin
            n_err++; $display("FAIL reset_drive got aluc=%b ina=%h inb=%h cin=%b", alu_aluc, alu_ina, alu_inb, alu_cin); end
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_add();
        start_op(4'd1, 32'h7FFF_FFFF, 32'h0000_0001);
        n_vec++; if ({busy, done, alu_aluc} !== {2'b10, 4'b0100}) begin
            n_err++; $display("FAIL add_p1 got busy=%b done=%b aluc=%b want 1 0 0100", busy, done, alu_aluc); end
        step();
        n_vec++; if ({busy, done} !== 2'b01) begin n_err++; $display("FAIL add_done got busy=%b done=%b want 0 1", busy, done); end
        n_vec++; if (result !== 32'h8000_0000) begin n_err++; $display("FAIL add_result got %h want 80000000", result); end
        n_vec++; if (flags !== 4'b1001) begin n_err++; $display("FAIL add_flags got %b want 1001", flags); end
        step();
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL add_done_pulse got %b want 0", done); end
    endtask

    task automatic test_sub();
        start_op(4'd3, 32'd5, 32'd3);
        n_vec++; if ({busy, alu_aluc, alu_inb} !== {1'b1, 4'b0011, 32'd3}) begin
            n_err++; $display("FAIL sub_p1 got busy=%b aluc=%b inb=%h", busy, alu_aluc, alu_inb); end
        step();
        n_vec++; if ({busy, done, alu_aluc, alu_ina, alu_inb, alu_cin} !== {2'b10, 4'b0101, 32'd5, 32'hFFFF_FFFC, 1'b1}) begin
            n_err++; $display("FAIL sub_p2 got busy=%b done=%b aluc=%b ina=%h inb=%h cin=%b want 1 0 0101 5 fffffffc 1",
                              busy, done, alu_aluc, alu_ina, alu_inb, alu_cin); end
        n_vec++; if (result !== 32'h8000_0000) begin n_err++; $display("FAIL sub_p1_result_held got %h want 80000000", result); end
        step();
        n_vec++; if ({done, result, flags} !== {1'b1, 32'd2, 4'b0010}) begin
            n_err++; $display("FAIL sub_done got done=%b result=%h flags=%b want 1 2 0010", done, result, flags); end
    endtask

    task automatic test_adc_neg();
        start_op(4'd2, 32'd1, 32'd1);
        n_vec++; if ({alu_aluc, alu_cin} !== {4'b0101, 1'b1}) begin
            n_err++; $display("FAIL adc_cin got aluc=%b cin=%b want 0101 1", alu_aluc, alu_cin); end
        step();
        n_vec++; if ({done, result, flags} !== {1'b1, 32'd3, 4'b0000}) begin
            n_err++; $display("FAIL adc_result got done=%b result=%h flags=%b want 1 3 0000", done, result, flags); end
        start_op(4'd4, 32'd1, 32'd0);
        n_vec++; if (alu_aluc !== 4'b0010) begin n_err++; $display("FAIL neg_p1 got aluc=%b want 0010", alu_aluc); end
        step();
        n_vec++; if ({alu_ina, alu_inb, alu_cin} !== {32'hFFFF_FFFE, 32'd0, 1'b1}) begin
            n_err++; $display("FAIL neg_p2 got ina=%h inb=%h cin=%b want fffffffe 0 1", alu_ina, alu_inb, alu_cin); end
        step();
        n_vec++; if ({done, result, flags} !== {1'b1, 32'hFFFF_FFFF, 4'b1000}) begin
            n_err++; $display("FAIL neg_result got done=%b result=%h flags=%b want 1 ffffffff 1000", done, result, flags); end
    endtask

    task automatic test_and_ignore();
        int dones;
        start_op(4'd3, 32'd5, 32'd3);
        step(); step();
        n_vec++; if (flags !== 4'b0010) begin n_err++; $display("FAIL and_pre_flags got %b want 0010", flags); end
        start_op(4'd5, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        start = 1'b1; op = 4'd1; opa = 32'd9; opb = 32'd9;
        step();
        start = 1'b0;
        n_vec++; if ({done, result, flags} !== {1'b1, 32'd0, 4'b0110}) begin
            n_err++; $display("FAIL and_result got done=%b result=%h flags=%b want 1 0 0110", done, result, flags); end
        dones = 0;
        repeat (4) begin step(); if (done) dones++; end
        n_vec++; if ({dones, busy, result} !== {32'd0, 1'b0, 32'd0}) begin
            n_err++; $display("FAIL start_ignored got extra_dones=%0d busy=%b result=%h want 0 0 0", dones, busy, result); end
    endtask

    task automatic test_back_to_back();
        start_op(4'd1, 32'd1, 32'd1);
        step();
        start = 1'b1; op = 4'd1; opa = 32'd2; opb = 32'd3;
        n_vec++; if ({done, result} !== {1'b1, 32'd2}) begin
            n_err++; $display("FAIL b2b_first got done=%b result=%h want 1 2", done, result); end
        step();
        start = 1'b0;
        n_vec++; if ({busy, done, alu_ina, alu_inb} !== {2'b10, 32'd2, 32'd3}) begin
            n_err++; $display("FAIL b2b_second_p1 got busy=%b done=%b ina=%h inb=%h", busy, done, alu_ina, alu_inb); end
        step();
        n_vec++; if ({done, result} !== {1'b1, 32'd5}) begin
            n_err++; $display("FAIL b2b_second got done=%b result=%h want 1 5", done, result); end
    endtask

    task automatic test_reset_mid();
        int dones;
        start_op(4'd3, 32'd9, 32'd4);
        step();
        #2 reset = 1'b1;
        #1;
        n_vec++; if ({busy, done, result, flags, alu_aluc, alu_ina, alu_inb, alu_cin} !== {2'b00, 32'd0, 4'b0000, 4'b1000, 65'd0}) begin
            n_err++; $display("FAIL reset_mid got busy=%b done=%b result=%h flags=%b aluc=%b ina=%h inb=%h cin=%b",
                              busy, done, result, flags, alu_aluc, alu_ina, alu_inb, alu_cin); end
        dones = 0;
        @(posedge clk); #1; if (done) dones++;
        @(negedge clk) reset = 1'b0;
        step(); if (done) dones++;
        n_vec++; if (dones !== 0) begin n_err++; $display("FAIL reset_mid_done got %0d pulses want 0", dones); end
        start_op(4'd1, 32'd2, 32'd2);
        step();
        n_vec++; if ({done, result, flags} !== {1'b1, 32'd4, 4'b0000}) begin
            n_err++; $display("FAIL reset_after_add got done=%b result=%h flags=%b want 1 4 0000", done, result, flags); end
    endtask

    task automatic test_cmp();
        start_op(4'd0, 32'h55, 32'h0);
        step();
        n_vec++; if ({result, flags} !== {32'h55, 4'b0000}) begin
            n_err++; $display("FAIL pass_result got result=%h flags=%b want 55 0000", result, flags); end
        start_op(4'd8, 32'd7, 32'd7);
`ifdef ALU_SEQ_CMP_EN
        step(); step();
        n_vec++; if ({done, result, flags} !== {1'b1, 32'h55, 4'b0110}) begin
            n_err++; $display("FAIL cmp_done got done=%b result=%h flags=%b want 1 55 0110", done, result, flags); end
`else
        n_vec++; if ({busy, alu_aluc, alu_ina, alu_inb} !== {1'b1, 4'b1000, 64'd0}) begin
            n_err++; $display("FAIL nop_drive got busy=%b aluc=%b ina=%h inb=%h want 1 1000 0 0", busy, alu_aluc, alu_ina, alu_inb); end
        step();
        n_vec++; if ({done, result, flags} !== {1'b1, 32'h55, 4'b0000}) begin
            n_err++; $display("FAIL nop_done got done=%b result=%h flags=%b want 1 55 0000", done, result, flags); end
`endif
        start_op(4'd12, 32'd1, 32'd1);
        step();
        n_vec++; if ({done, result} !== {1'b1, 32'h55}) begin
            n_err++; $display("FAIL nop12 got done=%b result=%h want 1 55", done, result); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_adc_neg();
        test_and_ignore();
        test_back_to_back();
        test_reset_mid();
        test_cmp();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout after 200000ns");
        $fatal(1);
    end
endmodule
